// File: rtl/gpio_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_bus_master
//  Purpose  : Initiator for the byte-wide GPIO/memory bus. Accepts byte or
//             16-bit little-endian word commands on a valid/ready channel,
//             issues them as single-byte bus accesses, and returns read data
//             and completion status on a response channel.
//  Ports    : clk, reset (async, active-high)
//             req_*  : command channel (valid/ready, write, word, addr, wdata)
//             rsp_*  : response channel (valid/ready, rdata, err)
//             bus_*  : responder side (address, rw_select, wdata, rdata)
//  Options  : GPIO_BUS_MASTER_RO_GUARD_EN - suppress writes to the read-only
//             input bytes 503..505 and flag them on rsp_err_o.
//  Revision : 1.0 - initial release
// ============================================================================
module gpio_bus_master #(
   parameter int ADDR_W    = 9,
   parameter int DATA_W    = 8,
   parameter int READ_WAIT = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_write_i,
   input  logic                req_word_i,
   input  logic [ADDR_W-1:0]   req_addr_i,
   input  logic [2*DATA_W-1:0] req_wdata_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [2*DATA_W-1:0] rsp_rdata_o,
   output logic                rsp_err_o,
   output logic [ADDR_W-1:0]   bus_address_o,
   output logic                bus_rw_select_o,
   output logic [DATA_W-1:0]   bus_wdata_o,
   input  logic [DATA_W-1:0]   bus_rdata_i
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LO   = 2'd1,
      S_HI   = 2'd2,
      S_RSP  = 2'd3
   } state_t;

   localparam logic [2:0] WAIT_LAST = 3'(READ_WAIT);

   state_t                state_q;
   logic                  req_ready_q;
   logic                  rsp_valid_q;
   logic [ADDR_W-1:0]     bus_address_q;
   logic [DATA_W-1:0]     bus_wdata_q;
   logic                  bus_rw_q;
   logic                  write_q;
   logic                  word_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [2*DATA_W-1:0]   wdata_q;
   logic [2*DATA_W-1:0]   rdata_q;
   logic                  err_q;
   logic [2:0]            wait_q;

   // Second byte address; natural wrap modulo 2**ADDR_W.
   logic [ADDR_W-1:0]     addr_hi_d;
   logic                  prot_lo_d;
   logic                  prot_hi_d;
   // Byte phase finishes this cycle: writes take one cycle, reads hold
   // the address for READ_WAIT+1 cycles.
   logic                  phase_done_d;

   assign addr_hi_d    = addr_q + ADDR_W'(1);
   assign phase_done_d = write_q || (wait_q == WAIT_LAST);

`ifdef GPIO_BUS_MASTER_RO_GUARD_EN
   // Bytes 503..505 are the button/switch inputs and must never be written.
   assign prot_lo_d = (req_addr_i == ADDR_W'(503)) || (req_addr_i == ADDR_W'(504)) ||
                      (req_addr_i == ADDR_W'(505));
   assign prot_hi_d = (addr_hi_d == ADDR_W'(503)) || (addr_hi_d == ADDR_W'(504)) ||
                      (addr_hi_d == ADDR_W'(505));
`else
   assign prot_lo_d = 1'b0;
   assign prot_hi_d = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         req_ready_q   <= 1'b1;
         rsp_valid_q   <= 1'b0;
         bus_address_q <= '0;
         bus_wdata_q   <= '0;
         bus_rw_q      <= 1'b0;
         write_q       <= 1'b0;
         word_q        <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         rdata_q       <= '0;
         err_q         <= 1'b0;
         wait_q        <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid_i) begin
                  write_q       <= req_write_i;
                  word_q        <= req_word_i;
                  addr_q        <= req_addr_i;
                  wdata_q       <= req_wdata_i;
                  rdata_q       <= '0;
                  err_q         <= req_write_i & prot_lo_d;
                  wait_q        <= '0;
                  bus_address_q <= req_addr_i;
                  bus_wdata_q   <= req_wdata_i[DATA_W-1:0];
                  bus_rw_q      <= req_write_i & ~prot_lo_d;
                  req_ready_q   <= 1'b0;
                  state_q       <= S_LO;
               end
            end
            S_LO: begin
               if (phase_done_d) begin
                  if (!write_q) rdata_q[DATA_W-1:0] <= bus_rdata_i;
                  wait_q <= '0;
                  if (word_q) begin
                     bus_address_q <= addr_hi_d;
                     bus_wdata_q   <= wdata_q[2*DATA_W-1:DATA_W];
                     bus_rw_q      <= write_q & ~prot_hi_d;
                     err_q         <= err_q | (write_q & prot_hi_d);
                     state_q       <= S_HI;
                  end else begin
                     bus_address_q <= '0;
                     bus_wdata_q   <= '0;
                     bus_rw_q      <= 1'b0;
                     rsp_valid_q   <= 1'b1;
                     state_q       <= S_RSP;
                  end
               end else begin
                  wait_q <= wait_q + 3'd1;
               end
            end
            S_HI: begin
               if (phase_done_d) begin
                  if (!write_q) rdata_q[2*DATA_W-1:DATA_W] <= bus_rdata_i;
                  wait_q        <= '0;
                  bus_address_q <= '0;
                  bus_wdata_q   <= '0;
                  bus_rw_q      <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  state_q       <= S_RSP;
               end else begin
                  wait_q <= wait_q + 3'd1;
               end
            end
            S_RSP: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
               bus_rw_q    <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready_o     = req_ready_q;
   assign rsp_valid_o     = rsp_valid_q;
   assign rsp_rdata_o     = rdata_q;
   assign rsp_err_o       = err_q;
   assign bus_address_o   = bus_address_q;
   assign bus_wdata_o     = bus_wdata_q;
   assign bus_rw_select_o = bus_rw_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpio_bus_master
//  Purpose  : Directed self-checking bench for gpio_bus_master. Two instances
//             (READ_WAIT=0 and READ_WAIT=2), each backed by a 512x8 RAM with
//             combinational read and posedge write.
//  Options  : honours GPIO_BUS_MASTER_RO_GUARD_EN for the guarded-write case.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_bus_master;

   logic        clk;
   logic        reset;
   logic        req_valid, req_valid1;
   logic        req_ready, req_ready1;
   logic        req_write;
   logic        req_word;
   logic [8:0]  req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid, rsp_valid1;
   logic        rsp_ready, rsp_ready1;
   logic [15:0] rsp_rdata, rsp_rdata1;
   logic        rsp_err, rsp_err1;
   logic [8:0]  bus_addr, bus_addr1;
   logic        bus_rw, bus_rw1;
   logic [7:0]  bus_wdata, bus_wdata1;
   logic [7:0]  bus_rdata, bus_rdata1;

   logic [7:0]  ram0 [0:511];
   logic [7:0]  ram1 [0:511];
   logic        ram_clr;
   logic        poke_en;
   logic [8:0]  poke_addr;
   logic [7:0]  poke_data;
   int          wr_cnt;
   logic [8:0]  last_wa;
   logic [7:0]  last_wd;

   int          n_cmp;
   int          n_bad;

   gpio_bus_master #(.ADDR_W(9), .DATA_W(8), .READ_WAIT(0)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_write_i(req_write), .req_word_i(req_word),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
      .bus_address_o(bus_addr), .bus_rw_select_o(bus_rw),
      .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata)
   );

   gpio_bus_master #(.ADDR_W(9), .DATA_W(8), .READ_WAIT(2)) u_dut_w2 (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid1), .req_ready_o(req_ready1),
      .req_write_i(req_write), .req_word_i(req_word),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid1), .rsp_ready_i(rsp_ready1),
      .rsp_rdata_o(rsp_rdata1), .rsp_err_o(rsp_err1),
      .bus_address_o(bus_addr1), .bus_rw_select_o(bus_rw1),
      .bus_wdata_o(bus_wdata1), .bus_rdata_i(bus_rdata1)
   );

   assign bus_rdata  = ram0[bus_addr];
   assign bus_rdata1 = ram1[bus_addr1];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Responder RAMs plus a write monitor on the primary instance.
   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 512; i++) begin
            ram0[i] <= 8'h00;
            ram1[i] <= 8'h00;
         end
         wr_cnt  <= 0;
         last_wa <= '0;
         last_wd <= '0;
      end else if (poke_en) begin
         ram0[poke_addr] <= poke_data;
         ram1[poke_addr] <= poke_data;
      end else begin
         if (bus_rw) begin
            ram0[bus_addr] <= bus_wdata;
            wr_cnt         <= wr_cnt + 1;
            last_wa        <= bus_addr;
            last_wd        <= bus_wdata;
         end
         if (bus_rw1) ram1[bus_addr1] <= bus_wdata1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [8:0] a, input logic [7:0] d);
      poke_en   = 1'b1;
      poke_addr = a;
      poke_data = d;
      tick();
      poke_en   = 1'b0;
   endtask

   // Present a command and return #1 after the accepting edge.
   task automatic send(input logic w, input logic wd, input logic [8:0] a, input logic [15:0] d);
      int n;
      n = 0;
      req_write = w;
      req_word  = wd;
      req_addr  = a;
      req_wdata = d;
      while (!req_ready && n < 64) begin
         tick();
         n++;
      end
      if (!req_ready) check("send_timeout", 32'd0, 32'd1);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
   endtask

   // Latency is reported as in T+n, where T is the accepting cycle.
   task automatic wait_rsp(output int lat, output logic [15:0] rd, output logic er);
      int n;
      n = 0;
      while (!rsp_valid && n < 64) begin
         tick();
         n++;
      end
      if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
      lat = n + 1;
      rd  = rsp_rdata;
      er  = rsp_err;
      if (rsp_ready) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      int          n;
      int          w0;
      logic [15:0] rd;
      logic        er;

      n_cmp      = 0;
      n_bad      = 0;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_valid1 = 1'b0;
      req_write  = 1'b0;
      req_word   = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      rsp_ready  = 1'b1;
      rsp_ready1 = 1'b1;
      ram_clr    = 1'b1;
      poke_en    = 1'b0;
      poke_addr  = '0;
      poke_data  = '0;
      repeat (3) tick();
      ram_clr = 1'b0;

      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_bus_rw",    {31'd0, bus_rw},    32'd0);
      check("rst_bus_addr",  {23'd0, bus_addr},  32'd0);
      check("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
      reset = 1'b0;
      tick();
      check("idle_req_ready", {31'd0, req_ready}, 32'd1);

      // 1: byte write 0x1FC
      w0 = wr_cnt;
      send(1'b1, 1'b0, 9'h1FC, 16'h0005);
      check("t1_bus_rw_lo", {31'd0, bus_rw}, 32'd1);
      wait_rsp(lat, rd, er);
      check("t1_latency", lat, 32'd2);
      check("t1_rdata", {16'd0, rd}, 32'd0);
      check("t1_err", {31'd0, er}, 32'd0);
      check("t1_writes", wr_cnt - w0, 32'd1);
      check("t1_wr_addr", {23'd0, last_wa}, 32'h1FC);
      check("t1_wr_data", {24'd0, last_wd}, 32'h05);
      check("t1_ram508", {24'd0, ram0[508]}, 32'h05);

      // 2: word read 0x1FA, READ_WAIT 0 and 2
      poke(9'd506, 8'h34);
      poke(9'd507, 8'h12);
      w0 = wr_cnt;
      send(1'b0, 1'b1, 9'h1FA, 16'h0000);
      wait_rsp(lat, rd, er);
      check("t2_latency", lat, 32'd3);
      check("t2_rdata", {16'd0, rd}, 32'h1234);
      check("t2_no_writes", wr_cnt - w0, 32'd0);
      req_write  = 1'b0;
      req_word   = 1'b1;
      req_addr   = 9'h1FA;
      req_valid1 = 1'b1;
      tick();
      req_valid1 = 1'b0;
      n = 0;
      while (!rsp_valid1 && n < 64) begin
         tick();
         n++;
      end
      check("t2_w2_latency", n + 1, 32'd7);
      check("t2_w2_rdata", {16'd0, rsp_rdata1}, 32'h1234);
      tick();
      check("t2_w2_released", {31'd0, rsp_valid1}, 32'd0);

      // 3: word write wrapping 511 -> 0, then read back the top byte
      w0 = wr_cnt;
      send(1'b1, 1'b1, 9'h1FF, 16'hBEEF);
      wait_rsp(lat, rd, er);
      check("t3_latency", lat, 32'd3);
      check("t3_writes", wr_cnt - w0, 32'd2);
      check("t3_ram511", {24'd0, ram0[511]}, 32'hEF);
      check("t3_ram0", {24'd0, ram0[0]}, 32'hBE);
      send(1'b0, 1'b0, 9'h1FF, 16'h0000);
      wait_rsp(lat, rd, er);
      check("t3_rd_latency", lat, 32'd2);
      check("t3_rd_data", {16'd0, rd}, 32'h00EF);

      // 4: response back-pressure with a queued command
      send(1'b1, 1'b1, 9'h010, 16'h1122);
      wait_rsp(lat, rd, er);
      rsp_ready = 1'b0;
      send(1'b0, 1'b1, 9'h010, 16'h0000);
      wait_rsp(lat, rd, er);
      check("t4_rdata", {16'd0, rd}, 32'h1122);
      req_write = 1'b0;
      req_word  = 1'b0;
      req_addr  = 9'h011;
      req_valid = 1'b1;
      w0 = wr_cnt;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t4_hold_valid", {31'd0, rsp_valid}, 32'd1);
         check("t4_hold_rdata", {16'd0, rsp_rdata}, 32'h1122);
         check("t4_hold_ready", {31'd0, req_ready}, 32'd0);
      end
      check("t4_no_writes", wr_cnt - w0, 32'd0);
      rsp_ready = 1'b1;
      tick();
      check("t4_rsp_dropped", {31'd0, rsp_valid}, 32'd0);
      check("t4_idle_ready", {31'd0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
      check("t4_accepted", {31'd0, req_ready}, 32'd0);
      check("t4_bus_addr", {23'd0, bus_addr}, 32'h011);
      wait_rsp(lat, rd, er);
      check("t4_q_latency", lat, 32'd2);
      check("t4_q_rdata", {16'd0, rd}, 32'h0011);

      // 5: reset during the high byte of a word write
      send(1'b1, 1'b1, 9'h020, 16'h6677);
      tick();
      check("t5_hi_rw", {31'd0, bus_rw}, 32'd1);
      reset = 1'b1;
      #1;
      check("t5_rw_dropped", {31'd0, bus_rw}, 32'd0);
      repeat (2) tick();
      check("t5_ram_lo", {24'd0, ram0[9'h020]}, 32'h77);
      check("t5_ram_hi", {24'd0, ram0[9'h021]}, 32'h00);
      reset = 1'b0;
      tick();
      check("t5_req_ready", {31'd0, req_ready}, 32'd1);
      check("t5_rsp_valid", {31'd0, rsp_valid}, 32'd0);

      // 6: word write touching the read-only input byte 503
      w0 = wr_cnt;
      send(1'b1, 1'b1, 9'h1F6, 16'hAA55);
      wait_rsp(lat, rd, er);
      check("t6_latency", lat, 32'd3);
      check("t6_ram502", {24'd0, ram0[502]}, 32'h55);
`ifdef GPIO_BUS_MASTER_RO_GUARD_EN
      check("t6_ram503", {24'd0, ram0[503]}, 32'h00);
      check("t6_err", {31'd0, er}, 32'd1);
      check("t6_writes", wr_cnt - w0, 32'd1);
`else
      check("t6_ram503", {24'd0, ram0[503]}, 32'hAA);
      check("t6_err", {31'd0, er}, 32'd0);
      check("t6_writes", wr_cnt - w0, 32'd2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
